// File: rtl/ub_activation_feeder_pkg.sv
// Shared types and default sizes for the unified-buffer activation feeder.
// FEEDER_PERF_CNT_EN adds the saturating busy-cycle counter helper.
package ub_feeder_pkg;

  localparam int unsigned LANES  = 8;
  localparam int unsigned ACT_W  = 8;
  localparam int unsigned ADDR_W = 15;
  localparam int unsigned CNT_W  = 12;
  localparam int unsigned DATA_W = LANES * ACT_W;
  localparam int unsigned PERF_W = 32;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } feeder_state_e;

  typedef logic [LANES-1:0][ACT_W-1:0] act_vec_t;

`ifdef FEEDER_PERF_CNT_EN
  function automatic logic [PERF_W-1:0] sat_inc(input logic [PERF_W-1:0] v);
    return (&v) ? v : v + PERF_W'(1);
  endfunction
`endif

endpackage

// File: rtl/ub_activation_feeder_if.sv
// Command, unified-buffer read and activation bus of the feeder.
// FEEDER_PERF_CNT_EN adds the perf_cycles result.
interface ub_activation_feeder_if;
  import ub_feeder_pkg::*;

  logic                 cmd_valid;
  logic                 cmd_ready;
  logic [ADDR_W-1:0]    cmd_base_addr;
  logic [CNT_W-1:0]     cmd_rows;
  logic                 ub_read;
  logic [ADDR_W-1:0]    ub_addr_rd;
  logic [DATA_W-1:0]    ub_data;
  act_vec_t             act_data;
  logic [LANES-1:0]     act_lane_valid;
  logic                 busy;
  logic                 done;
`ifdef FEEDER_PERF_CNT_EN
  logic [PERF_W-1:0]    perf_cycles;
`endif

  // Feeder side
  modport slave (
    input  cmd_valid, cmd_base_addr, cmd_rows, ub_data,
    output cmd_ready, ub_read, ub_addr_rd, act_data, act_lane_valid, busy, done
`ifdef FEEDER_PERF_CNT_EN
    , output perf_cycles
`endif
  );

  // Command issuer / unified buffer / array side
  modport master (
    output cmd_valid, cmd_base_addr, cmd_rows, ub_data,
    input  cmd_ready, ub_read, ub_addr_rd, act_data, act_lane_valid, busy, done
`ifdef FEEDER_PERF_CNT_EN
    , input perf_cycles
`endif
  );

endinterface

// File: rtl/ub_activation_feeder_skew_delay_line.sv
// Per-lane shift register of DEPTH stages carrying data plus a valid bit.
// DEPTH=0 is a plain pass-through.
module skew_delay_line #(
  parameter int unsigned DEPTH = 1,
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] data,
  input  logic             valid,
  output logic [WIDTH-1:0] delayed_data,
  output logic             delayed_valid
);

  if (DEPTH == 0) begin : g_pass
    logic unused_clk;
    assign unused_clk    = &{1'b0, clk, rst_n};
    assign delayed_data  = data;
    assign delayed_valid = valid;
  end else begin : g_shift
    logic [WIDTH-1:0] data_q [DEPTH];
    logic [DEPTH-1:0] valid_q;

    always_ff @(posedge clk) begin
      if (!rst_n) begin
        for (int i = 0; i < int'(DEPTH); i++) data_q[i] <= '0;
        valid_q <= '0;
      end else begin
        data_q[0]  <= data;
        valid_q[0] <= valid;
        for (int i = 1; i < int'(DEPTH); i++) begin
          data_q[i]  <= data_q[i-1];
          valid_q[i] <= valid_q[i-1];
        end
      end
    end

    assign delayed_data  = data_q[DEPTH-1];
    assign delayed_valid = valid_q[DEPTH-1];
  end

endmodule

// File: rtl/ub_activation_feeder.sv
// Streams unified-buffer rows into the systolic array as diagonally skewed lanes.
// Define FEEDER_PERF_CNT_EN to report busy cycles of the last command.
module ub_activation_feeder
  import ub_feeder_pkg::*;
(
  input logic                   clk_i,
  input logic                   rst_i,
  ub_activation_feeder_if.slave bus
);

  feeder_state_e     state, state_next;
  logic [ADDR_W-1:0] addr_q, addr_d, ub_addr_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              accept;
  logic              cmd_ready_d, busy_d, done_d, ub_read_d;
  logic              rd_q, cap_valid;
  act_vec_t          cap_data, act_out;
  logic [LANES-1:0]  lane_valid;

  assign accept = bus.cmd_valid & bus.cmd_ready;

  always_ff @(posedge clk_i) begin
    if (!rst_i) state <= IDLE;
    else        state <= state_next;
  end

  // cnt_q counts remaining reads in READ, then remaining drain cycles in DRAIN
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (accept) state_next = (bus.cmd_rows == '0) ? DONE : READ;
      READ:    if (cnt_q == CNT_W'(1)) state_next = DRAIN;
      DRAIN:   if (cnt_q == '0) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    cmd_ready_d = (state_next == IDLE);
    busy_d      = (state_next != IDLE);
    done_d      = (state == DONE);
    ub_read_d   = (state == READ);
    ub_addr_d   = ub_read_d ? addr_q : '0;
    addr_d      = addr_q;
    cnt_d       = cnt_q;
    case (state)
      IDLE: begin
        if (accept) begin
          addr_d = bus.cmd_base_addr;
          cnt_d  = bus.cmd_rows;
        end
      end
      READ: begin
        addr_d = addr_q + ADDR_W'(1);
        cnt_d  = (cnt_q == CNT_W'(1)) ? CNT_W'(LANES) : cnt_q - CNT_W'(1);
      end
      DRAIN: if (cnt_q != '0) cnt_d = cnt_q - CNT_W'(1);
      default: ;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      addr_q         <= '0;
      cnt_q          <= '0;
      bus.cmd_ready  <= 1'b1;
      bus.busy       <= 1'b0;
      bus.done       <= 1'b0;
      bus.ub_read    <= 1'b0;
      bus.ub_addr_rd <= '0;
    end else begin
      addr_q         <= addr_d;
      cnt_q          <= cnt_d;
      bus.cmd_ready  <= cmd_ready_d;
      bus.busy       <= busy_d;
      bus.done       <= done_d;
      bus.ub_read    <= ub_read_d;
      bus.ub_addr_rd <= ub_addr_d;
    end
  end

  // Read data arrives one cycle after the strobe; idle slots inject zeros
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      rd_q      <= 1'b0;
      cap_valid <= 1'b0;
      cap_data  <= '0;
    end else begin
      rd_q      <= bus.ub_read;
      cap_valid <= rd_q;
      cap_data  <= rd_q ? act_vec_t'(bus.ub_data) : '0;
    end
  end

  for (genvar k = 0; k < int'(LANES); k++) begin : g_lane
    skew_delay_line #(
      .DEPTH (k),
      .WIDTH (ACT_W)
    ) u_skew (
      .clk           (clk_i),
      .rst_n         (rst_i),
      .data          (cap_data[k]),
      .valid         (cap_valid),
      .delayed_data  (act_out[k]),
      .delayed_valid (lane_valid[k])
    );
  end

  assign bus.act_data       = act_out;
  assign bus.act_lane_valid = lane_valid;

`ifdef FEEDER_PERF_CNT_EN
  logic [PERF_W-1:0] busy_cnt;

  // The DONE cycle is itself busy, so it is folded into the published value
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      busy_cnt        <= '0;
      bus.perf_cycles <= '0;
    end else if (state == DONE) begin
      busy_cnt        <= '0;
      bus.perf_cycles <= sat_inc(busy_cnt);
    end else if (bus.busy) begin
      busy_cnt <= sat_inc(busy_cnt);
    end
  end
`endif

endmodule
